rx_axis_frame_fifo: RTL
=======================

Name: rx_axis_frame_fifo

Overview:
- Parametrised store-and-forward frame buffer placed after the receive MAC's registered AXIS output.
- Adds downstream backpressure (m00_axis_tready), which the receive MAC does not provide.
- Optionally discards frames flagged bad (tuser on the last beat, FCS error).
- Discards frames that overflow the buffer and counts every dropped frame. Supports 32- or 64-bit datapaths.

Parameters:
- DATA_WIDTH, 32, AXIS data width; 32 or 64 only.
- DATA_NBYTES, DATA_WIDTH/8, derived byte count; localparam.
- DEPTH, 512, storage depth in beats; power of two, >= 4.
- DROP_BAD_FRAMES, 1, 1 = discard frames with tuser=1 on tlast; 0 = forward them with tuser on the last beat.
- COUNT_WIDTH, 16, width of the drop counter.

Ports:
- i_clk  in  1  clock for both write and read sides.
- i_reset  in  1  asynchronous, active-high reset.
- s00_axis_tdata  in  DATA_WIDTH  receive data from the MAC.
- s00_axis_tkeep  in  DATA_NBYTES  byte enables; stored unmodified.
- s00_axis_tvalid  in  1  beat valid; no tready exists, so every valid beat must be consumed or dropped.
- s00_axis_tlast  in  1  end of frame.
- s00_axis_tuser  in  1  frame error; sampled on the tlast beat only.
- m00_axis_tdata  out  DATA_WIDTH  buffered data.
- m00_axis_tkeep  out  DATA_NBYTES  buffered byte enables.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  end of frame.
- m00_axis_tuser  out  1  error flag; can be 1 only when DROP_BAD_FRAMES=0, and only on the tlast beat.
- o_overflow  out  1  one-cycle pulse when a frame is discarded for lack of space.
- o_bad_drop  out  1  one-cycle pulse when a bad frame is discarded.
- o_drop_count  out  COUNT_WIDTH  saturating count of all discarded frames.

Behaviour:
- Reset (async): all m00 outputs, o_overflow, o_bad_drop, o_drop_count = 0; every pointer = 0; write FSM = IDLE. A frame in progress at reset is lost. Stale RAM contents are never presented.
- Storage: DEPTH entries of {tuser, tlast, tkeep, tdata}, registered read port.
- Pointers: wr_ptr (speculative), wr_commit, rd_ptr; each log2(DEPTH)+1 bits, wrapping naturally.
- Full condition: wr_ptr - rd_ptr == DEPTH, evaluated on registered pointers. A read in the same cycle frees space from the next cycle only.
- Write FSM:
  - IDLE: a valid beat starts a frame. That beat, and every later valid beat, is handled as in WRITE.
  - WRITE: each valid beat is written at wr_ptr and wr_ptr increments, unless full.
    - Full on any beat without tlast: wr_ptr <= wr_commit, pulse o_overflow, go to DISCARD.
    - Full on the tlast beat: same rewind and o_overflow pulse, go to IDLE.
    - tlast beat written with tuser=1 and DROP_BAD_FRAMES=1: wr_ptr <= wr_commit, pulse o_bad_drop, go to IDLE.
    - tlast beat written otherwise: wr_commit <= wr_ptr+1, go to IDLE.
  - DISCARD: ignore all beats. The tlast beat returns the FSM to IDLE with no further pulse.
- Single-beat frames (tvalid and tlast in the same cycle from IDLE) follow the same rules.
- o_drop_count increments by 1 on each o_overflow or o_bad_drop pulse and saturates at all-ones. The two pulses are never asserted together.
- Read side: a committed beat exists while rd_ptr != wr_commit. Uncommitted beats are never output.
- Output register: loaded from RAM when empty or when (tvalid && tready). It holds all fields stable while tvalid && !tready.
- Back-to-back beats at full throughput when tready stays high; no bubbles between committed frames.
- Latency: if the last beat is sampled at edge k and the output is idle, m00_axis_tvalid=1 after edge k+2.
- Frame atomicity: a frame is output entirely or not at all, and frame order is preserved.
- tkeep is passed through without inspection.

Test Plan:
- DATA_WIDTH=32, DEPTH=16, tready=1; 3-beat good frame, last tkeep=4'b0011 -> identical 3 beats out; tvalid rises 2 edges after the input tlast; drop_count=0.
- DROP_BAD_FRAMES=1; 4-beat frame with tuser=1 on tlast, then a 2-beat good frame -> only the 2-beat frame is output; o_bad_drop pulses once; drop_count=1.
- DROP_BAD_FRAMES=0; same bad frame -> all 4 beats output with m00_axis_tuser=1 only on the last beat; drop_count=0.
- DEPTH=8, tready=0; frame A of 6 beats then frame B of 5 beats -> B overflows at its 3rd beat, one o_overflow pulse, B's remaining beats ignored; tready=1 then yields exactly A.
- tready toggled randomly; 50 frames of 1-20 beats, DATA_WIDTH=64 -> output equals input frame-for-frame; data stable while stalled.
- Assert i_reset mid-frame during output -> all outputs 0 immediately; after release a new 2-beat frame emerges cleanly with no residue; drop_count=0.

Source files
------------

// File: rtl/rx_axis_frame_fifo.sv
// Store-and-forward receive frame buffer: commits whole frames, drops bad or overflowing
// frames, and adds downstream backpressure behind a two-stage registered read pipeline.
module rx_axis_frame_fifo #(
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 512,
   parameter bit DROP_BAD_FRAMES = 1'b1,
   parameter int COUNT_WIDTH     = 16,
   localparam int DATA_NBYTES    = DATA_WIDTH / 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
   input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
   input  logic                   s00_axis_tvalid,
   input  logic                   s00_axis_tlast,
   input  logic                   s00_axis_tuser,
   output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
   output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
   output logic                   m00_axis_tvalid,
   input  logic                   m00_axis_tready,
   output logic                   m00_axis_tlast,
   output logic                   m00_axis_tuser,
   output logic                   o_overflow,
   output logic                   o_bad_drop,
   output logic [COUNT_WIDTH-1:0] o_drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = DATA_WIDTH + DATA_NBYTES + 2;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   // S_IDLE: between frames | S_WRITE: storing a frame | S_DISCARD: dropping rest of an overflowed frame
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;

   state_t                 r_state, w_state_nxt;
   logic [PW-1:0]          r_wr_ptr, r_wr_commit, r_rd_ptr, r_fetch_ptr;
   logic [PW-1:0]          w_wr_ptr_nxt, w_wr_commit_nxt;
   logic [EW-1:0]          r_mem [DEPTH];
   logic [EW-1:0]          r_ram_q;
   logic                   r_ram_valid;
   logic [DATA_WIDTH-1:0]  r_m_tdata;
   logic [DATA_NBYTES-1:0] r_m_tkeep;
   logic                   r_m_tvalid, r_m_tlast, r_m_tuser;
   logic                   r_overflow, r_bad_drop;
   logic [COUNT_WIDTH-1:0] r_drop_count;
   logic                   w_full, w_wr_en, w_ovf, w_bad;
   logic                   w_out_ld, w_s1_ld, w_rd_en;
   logic [EW-1:0]          w_wr_entry;

   // Space is released only when a beat leaves the output, so pipelined beats still occupy it.
   assign w_full     = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
   assign w_wr_entry = {s00_axis_tuser & s00_axis_tlast, s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
   assign w_out_ld   = !r_m_tvalid || m00_axis_tready;
   assign w_s1_ld    = !r_ram_valid || w_out_ld;
   assign w_rd_en    = (r_fetch_ptr != r_wr_commit) && w_s1_ld;

   always_comb begin
      w_state_nxt      = r_state;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_wr_commit_nxt  = r_wr_commit;
      w_wr_en          = 1'b0;
      w_ovf            = 1'b0;
      w_bad            = 1'b0;
      case (r_state)
         S_IDLE, S_WRITE: begin
            if (s00_axis_tvalid) begin
               if (w_full) begin
                  w_wr_ptr_nxt = r_wr_commit;
                  w_ovf        = 1'b1;
                  w_state_nxt  = s00_axis_tlast ? S_IDLE : S_DISCARD;
               end else begin
                  w_wr_en = 1'b1;
                  if (!s00_axis_tlast) begin
                     w_wr_ptr_nxt = r_wr_ptr + PW'(1);
                     w_state_nxt  = S_WRITE;
                  end else if (DROP_BAD_FRAMES && s00_axis_tuser) begin
                     w_wr_ptr_nxt = r_wr_commit;
                     w_bad        = 1'b1;
                     w_state_nxt  = S_IDLE;
                  end else begin
                     w_wr_ptr_nxt    = r_wr_ptr + PW'(1);
                     w_wr_commit_nxt = r_wr_ptr + PW'(1);
                     w_state_nxt     = S_IDLE;
                  end
               end
            end
         end
         S_DISCARD: begin
            if (s00_axis_tvalid && s00_axis_tlast) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
      if (w_rd_en) r_ram_q <= r_mem[r_fetch_ptr[AW-1:0]];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_wr_commit  <= '0;
         r_rd_ptr     <= '0;
         r_fetch_ptr  <= '0;
         r_ram_valid  <= 1'b0;
         r_m_tvalid   <= 1'b0;
         r_m_tdata    <= '0;
         r_m_tkeep    <= '0;
         r_m_tlast    <= 1'b0;
         r_m_tuser    <= 1'b0;
         r_overflow   <= 1'b0;
         r_bad_drop   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_wr_commit <= w_wr_commit_nxt;
         if (w_rd_en) begin
            r_fetch_ptr <= r_fetch_ptr + PW'(1);
            r_ram_valid <= 1'b1;
         end else if (w_s1_ld) begin
            r_ram_valid <= 1'b0;
         end
         if (w_out_ld) begin
            r_m_tvalid <= r_ram_valid;
            r_m_tdata  <= r_ram_valid ? r_ram_q[DATA_WIDTH-1:0] : '0;
            r_m_tkeep  <= r_ram_valid ? r_ram_q[DATA_WIDTH +: DATA_NBYTES] : '0;
            r_m_tlast  <= r_ram_valid & r_ram_q[EW-2];
            r_m_tuser  <= r_ram_valid & r_ram_q[EW-1];
         end
         if (r_m_tvalid && m00_axis_tready) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_overflow <= w_ovf;
         r_bad_drop <= w_bad;
         if ((w_ovf || w_bad) && (r_drop_count != '1)) r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
      end
   end

   assign m00_axis_tdata  = r_m_tdata;
   assign m00_axis_tkeep  = r_m_tkeep;
   assign m00_axis_tvalid = r_m_tvalid;
   assign m00_axis_tlast  = r_m_tlast;
   assign m00_axis_tuser  = r_m_tuser;
   assign o_overflow      = r_overflow;
   assign o_bad_drop      = r_bad_drop;
   assign o_drop_count    = r_drop_count;

endmodule
